// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the conv-layer output streaming path.
// Holds LeNet conv1 default geometry, the fp32 zero word and the streamer FSM states.
package cnn_stream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_D          = 6;
    localparam int DEF_H          = 28;
    localparam int DEF_W          = 28;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } streamer_state_e;

endpackage

// File: rtl/conv_coord_counter.sv
// Channel/row/column counter walking a D x H x W volume in raster order.
// Ports: clk, reset (sync, active-high), clear, inc, ch/row/col (current), last (at D-1/H-1/W-1).
module conv_coord_counter
    import cnn_stream_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int H = DEF_H,
    parameter int W = DEF_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [$clog2(D)-1:0] ch,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic                 last
);

    localparam int CHW  = $clog2(D);
    localparam int ROWW = $clog2(H);
    localparam int COLW = $clog2(W);

    logic [CHW-1:0]  ch_q,  ch_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [COLW-1:0] col_q, col_d;

    logic col_end, row_end, ch_end;

    assign col_end = (col_q == COLW'(W - 1));
    assign row_end = (row_q == ROWW'(H - 1));
    assign ch_end  = (ch_q  == CHW'(D - 1));

    always_comb begin
        ch_d  = ch_q;
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            ch_d  = '0;
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                    ch_d  = ch_end ? '0 : ch_q + CHW'(1);
                end else begin
                    row_d = row_q + ROWW'(1);
                end
            end else begin
                col_d = col_q + COLW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q  <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            ch_q  <= ch_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign ch   = ch_q;
    assign row  = row_q;
    assign col  = col_q;
    assign last = ch_end & row_end & col_end;

endmodule

// File: rtl/conv_output_streamer.sv
// Captures the flat conv-layer result bus on start and streams it one word per cycle
// over valid/ready with ch/row/col coordinates, first/last markers and a done pulse.
// Ports: clk, reset (sync, active-high), outputConv/start in; busy, out_* stream, done out;
// out_ready in. Build option STREAMER_RELU_EN zeroes every word whose sign bit is set.
module conv_output_streamer
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int D          = DEF_D,
    parameter int H          = DEF_H,
    parameter int W          = DEF_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [D*H*W*DATA_WIDTH-1:0]  outputConv,
    input  logic                         start,
    output logic                         busy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(D)-1:0]         out_ch,
    output logic [$clog2(H)-1:0]         out_row,
    output logic [$clog2(W)-1:0]         out_col,
    output logic                         out_first,
    output logic                         out_last,
    output logic                         done
);

    localparam int N  = D * H * W;
    localparam int CW = $clog2(N);

    streamer_state_e state_q, state_d;

    logic                  busy_q,  busy_d;
    logic                  valid_q, valid_d;
    logic                  done_q,  done_d;
    logic                  first_q, first_d;
    logic                  last_q,  last_d;
    logic [CW-1:0]         idx_q,   idx_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic [N*DATA_WIDTH-1:0] cap_q;

    logic          cap_load;
    logic          cnt_clear;
    logic          cnt_inc;
    logic          cnt_last;
    logic          hs;
    logic [CW-1:0] nxt_idx;

    // ReLU sits on the emit path only, so the capture keeps raw values.
    function automatic logic [DATA_WIDTH-1:0] emit(input logic [DATA_WIDTH-1:0] w);
`ifdef STREAMER_RELU_EN
        return w[DATA_WIDTH-1] ? DATA_WIDTH'(FP32_ZERO) : w;
`else
        return w;
`endif
    endfunction

    assign hs      = valid_q & out_ready;
    assign nxt_idx = idx_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        first_d   = first_q;
        last_d    = last_q;
        idx_d     = idx_q;
        data_d    = data_q;
        cap_load  = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Word 0 comes straight off the bus so it is valid next cycle.
                    cap_load  = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = ST_STREAM;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    idx_d     = '0;
                    data_d    = emit(outputConv[DATA_WIDTH-1:0]);
                    first_d   = 1'b1;
                    last_d    = (N == 1);
                end
            end
            ST_STREAM: begin
                if (hs) begin
                    if (cnt_last) begin
                        cnt_clear = 1'b1;
                        state_d   = ST_IDLE;
                        busy_d    = 1'b0;
                        valid_d   = 1'b0;
                        done_d    = 1'b1;
                        first_d   = 1'b0;
                        last_d    = 1'b0;
                    end else begin
                        cnt_inc = 1'b1;
                        idx_d   = nxt_idx;
                        data_d  = emit(cap_q[int'(nxt_idx)*DATA_WIDTH +: DATA_WIDTH]);
                        first_d = 1'b0;
                        last_d  = (nxt_idx == CW'(N - 1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            first_q <= first_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Wide capture has no reset; it is only read while a frame is active.
    always_ff @(posedge clk) begin
        if (cap_load) begin
            cap_q <= outputConv;
        end
    end

    conv_coord_counter #(
        .D (D),
        .H (H),
        .W (W)
    ) u_coord (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .ch    (out_ch),
        .row   (out_row),
        .col   (out_col),
        .last  (cnt_last)
    );

    assign busy      = busy_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign done      = done_q;

endmodule
